// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store initiator for the byte-addressed data memory.
// Runs one access at a time through the data_valid low/high handshake, with alignment, funct3 and timeout traps.
module load_store_unit #(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           wdata,
  output logic                  mem_we,
  output logic [3:0]            mem_op,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_data_valid,
  input  logic [31:0]           mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           load_data,
  output logic                  misaligned,
  output logic                  bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_BUMP, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  is_store_q, is_store_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  bumping_q, bumping_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic                  last_addr_vld_q, last_addr_vld_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mem_we_q, mem_we_d;
  logic [3:0]            mem_op_q, mem_op_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [31:0]           load_data_q, load_data_d;
  logic                  misaligned_q, misaligned_d;
  logic                  bus_err_q, bus_err_d;

  logic                  f3_legal;
  logic                  misalign;
  logic                  tmo_hit;
  logic                  issue_req;
  logic                  phase_tmo;
  logic [3:0]            req_op;
  logic [31:0]           ext_data;
  logic                  unused_addr_hi;

  assign unused_addr_hi = ^addr[31:ADDR_WIDTH];

  // Loads allow 000,001,010,100,101; stores allow 000,001,010.
  assign f3_legal = is_store_q ? (!funct3_q[2] && funct3_q[1:0] != 2'b11)
                               : (funct3_q[1:0] != 2'b11 && !(funct3_q[2] && funct3_q[1]));
  assign misalign = (funct3_q[1:0] == 2'b01 && addr_q[0]) ||
                    (funct3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
  assign tmo_hit  = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    req_op = 4'b1111;
    if (is_store_q) begin
      case (funct3_q[1:0])
        2'b00:   req_op = 4'b0001;
        2'b01:   req_op = 4'b0011;
        default: req_op = 4'b1111;
      endcase
    end
  end

  always_comb begin
    ext_data = mem_rdata;
    case (funct3_q)
      3'b000:  ext_data = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'b001:  ext_data = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b100:  ext_data = {24'h0, mem_rdata[7:0]};
      3'b101:  ext_data = {16'h0, mem_rdata[15:0]};
      default: ext_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    is_store_d      = is_store_q;
    funct3_d        = funct3_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    bumping_d       = bumping_q;
    last_addr_d     = last_addr_q;
    last_addr_vld_d = last_addr_vld_q;
    cnt_d           = cnt_q;
    mem_we_d        = mem_we_q;
    mem_op_d        = mem_op_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    busy_d          = busy_q;
    load_data_d     = load_data_q;
    done_d          = 1'b0;
    misaligned_d    = 1'b0;
    bus_err_d       = 1'b0;
    issue_req       = 1'b0;
    phase_tmo       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_store_d = is_store;
          funct3_d   = funct3;
          addr_d     = addr[ADDR_WIDTH-1:0];
          wdata_d    = wdata;
          busy_d     = 1'b1;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!f3_legal) begin
          bus_err_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end else if (misalign) begin
          misaligned_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end else if (!last_addr_vld_q || addr_q == last_addr_q) begin
          // The memory only starts on an address change, so detour through a dummy read.
          state_d    = S_BUMP;
          bumping_d  = 1'b1;
          mem_addr_d = addr_q ^ ADDR_WIDTH'(1);
          mem_we_d   = 1'b0;
          mem_op_d   = 4'b1111;
        end else begin
          issue_req = 1'b1;
        end
      end
      S_BUMP, S_ISSUE: begin
        state_d = S_WAIT_LO;
        cnt_d   = '0;
      end
      S_WAIT_LO: begin
        if (!mem_data_valid) begin
          state_d = S_WAIT_HI;
          cnt_d   = '0;
        end else if (tmo_hit) begin
          phase_tmo = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_HI: begin
        if (mem_data_valid) begin
          if (bumping_q) begin
            bumping_d = 1'b0;
            issue_req = 1'b1;
          end else begin
            state_d         = S_DONE;
            done_d          = 1'b1;
            busy_d          = 1'b0;
            mem_we_d        = 1'b0;
            mem_op_d        = 4'b0000;
            last_addr_d     = addr_q;
            last_addr_vld_d = 1'b1;
            if (!is_store_q) load_data_d = ext_data;
          end
        end else if (tmo_hit) begin
          phase_tmo = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (issue_req) begin
      state_d     = S_ISSUE;
      mem_addr_d  = addr_q;
      mem_we_d    = is_store_q;
      mem_op_d    = req_op;
      mem_wdata_d = wdata_q;
    end

    if (phase_tmo) begin
      state_d         = S_IDLE;
      bus_err_d       = 1'b1;
      busy_d          = 1'b0;
      mem_we_d        = 1'b0;
      mem_op_d        = 4'b0000;
      last_addr_vld_d = 1'b0;
      bumping_d       = 1'b0;
      cnt_d           = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      is_store_q      <= 1'b0;
      funct3_q        <= 3'b000;
      addr_q          <= '0;
      wdata_q         <= '0;
      bumping_q       <= 1'b0;
      last_addr_q     <= '0;
      last_addr_vld_q <= 1'b0;
      cnt_q           <= '0;
      mem_we_q        <= 1'b0;
      mem_op_q        <= 4'b0000;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      load_data_q     <= '0;
      misaligned_q    <= 1'b0;
      bus_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      is_store_q      <= is_store_d;
      funct3_q        <= funct3_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      bumping_q       <= bumping_d;
      last_addr_q     <= last_addr_d;
      last_addr_vld_q <= last_addr_vld_d;
      cnt_q           <= cnt_d;
      mem_we_q        <= mem_we_d;
      mem_op_q        <= mem_op_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      load_data_q     <= load_data_d;
      misaligned_q    <= misaligned_d;
      bus_err_q       <= bus_err_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_op     = mem_op_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign load_data  = load_data_q;
  assign misaligned = misaligned_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit with a byte-lane memory model.
module tb_load_store_unit;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, is_store;
  logic [2:0]    funct3;
  logic [31:0]   addr, wdata;
  logic          mem_we;
  logic [3:0]    mem_op;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_data_valid;
  logic [31:0]   mem_rdata;
  logic          busy, done, misaligned, bus_err;
  logic [31:0]   load_data;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(AW), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .mem_we(mem_we), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_data_valid(mem_data_valid), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .load_data(load_data), .misaligned(misaligned), .bus_err(bus_err)
  );

  // Memory: an address change starts an access; valid drops, then rises after mem_lat extra cycles.
  logic [7:0]    mem [4096];
  logic [AW-1:0] prev_addr;
  logic          pend;
  int            wait_cnt;
  int            mem_lat   = 0;
  bit            stuck     = 1'b0;
  bit            mem_clear = 1'b0;
  int            accesses  = 0;

  assign mem_rdata = {mem[mem_addr + 12'd3], mem[mem_addr + 12'd2], mem[mem_addr + 12'd1], mem[mem_addr]};

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'(i);
      prev_addr      <= mem_addr;
      pend           <= 1'b0;
      wait_cnt       <= 0;
      mem_data_valid <= 1'b1;
    end else if (mem_addr != prev_addr) begin
      prev_addr <= mem_addr;
      if (!stuck) begin
        mem_data_valid <= 1'b0;
        pend           <= 1'b1;
        wait_cnt       <= mem_lat;
        accesses       <= accesses + 1;
      end
    end else if (pend) begin
      if (wait_cnt != 0) begin
        wait_cnt <= wait_cnt - 1;
      end else begin
        if (mem_we)
          for (int i = 0; i < 4; i++)
            if (mem_op[i]) mem[mem_addr + 12'(i)] <= mem_wdata[8*i +: 8];
        mem_data_valid <= 1'b1;
        pend           <= 1'b0;
      end
    end
  end

  int          r_cyc;
  bit          r_done, r_mis, r_err, r_bump, r_we;
  logic [3:0]  r_op;
  logic [31:0] r_wdata;

  task automatic do_op(input string nm, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    r_bump = 1'b0; r_op = 4'b0000; r_we = 1'b0; r_wdata = '0;
    @(negedge clk);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    start = 1'b0;
    r_cyc = 1;
    while (!(done || misaligned || bus_err) && r_cyc < 60) begin
      @(negedge clk);
      r_cyc++;
      if (busy || done) begin
        if (mem_addr == (a[AW-1:0] ^ 12'h001)) r_bump = 1'b1;
        if (mem_addr == a[AW-1:0] && mem_op != 4'b0000) begin
          r_op = mem_op; r_we = mem_we; r_wdata = mem_wdata;
        end
      end
    end
    r_done = done; r_mis = misaligned; r_err = bus_err;
    if (r_cyc >= 60) begin
      total++;
      $display("FAIL %s: no done/misaligned/bus_err within 60 cycles", nm);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    mem_clear = 1'b1;
    repeat (2) @(negedge clk);
    mem_clear = 1'b0;
    total++;
    if ({busy, done, misaligned, bus_err, mem_we, mem_op} !== 9'b0 || mem_addr !== 12'h000 ||
        mem_wdata !== 32'h0 || load_data !== 32'h0)
      $display("FAIL reset_outputs: busy=%b done=%b mis=%b err=%b we=%b op=%b addr=%h wdata=%h ld=%h, all required 0",
               busy, done, misaligned, bus_err, mem_we, mem_op, mem_addr, mem_wdata, load_data);
    else passed++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || mem_data_valid !== 1'b1)
      $display("FAIL reset_idle: busy=%b valid=%b required busy=0 valid=1", busy, mem_data_valid);
    else passed++;
  endtask

  task automatic test_word();
    do_op("sw_010", 1'b1, 3'b010, 32'h010, 32'hDEADBEEF);
    total++;
    if (!r_done || r_err || r_mis || r_cyc != 8 || !r_bump)
      $display("FAIL sw_010_flow: done=%b err=%b mis=%b cycles=%0d bump=%b required done=1 cycles=8 bump=1",
               r_done, r_err, r_mis, r_cyc, r_bump);
    else passed++;
    total++;
    if (r_op !== 4'b1111 || r_we !== 1'b1 || r_wdata !== 32'hDEADBEEF)
      $display("FAIL sw_010_req: op=%b we=%b wdata=%h required op=1111 we=1 wdata=deadbeef", r_op, r_we, r_wdata);
    else passed++;
    do_op("lw_010", 1'b0, 3'b010, 32'h010, 32'h0);
    total++;
    if (!r_done || r_cyc != 8 || !r_bump || r_we !== 1'b0 || r_op !== 4'b1111)
      $display("FAIL lw_010_flow: done=%b cycles=%0d bump=%b we=%b op=%b required done=1 cycles=8 bump=1 we=0 op=1111",
               r_done, r_cyc, r_bump, r_we, r_op);
    else passed++;
    total++;
    if (load_data !== 32'hDEADBEEF)
      $display("FAIL lw_010_data: load_data=%h required deadbeef", load_data);
    else passed++;
  endtask

  task automatic test_byte();
    do_op("sb_021", 1'b1, 3'b000, 32'h021, 32'h000000AA);
    total++;
    if (!r_done || r_cyc != 5 || r_bump || r_op !== 4'b0001 || r_we !== 1'b1)
      $display("FAIL sb_021: done=%b cycles=%0d bump=%b op=%b we=%b required done=1 cycles=5 bump=0 op=0001 we=1",
               r_done, r_cyc, r_bump, r_op, r_we);
    else passed++;
    do_op("lb_021", 1'b0, 3'b000, 32'h021, 32'h0);
    total++;
    if (!r_done || load_data !== 32'hFFFFFFAA)
      $display("FAIL lb_021: done=%b load_data=%h required done=1 ffffffaa", r_done, load_data);
    else passed++;
    do_op("lbu_021", 1'b0, 3'b100, 32'h021, 32'h0);
    total++;
    if (!r_done || load_data !== 32'h000000AA)
      $display("FAIL lbu_021: done=%b load_data=%h required done=1 000000aa", r_done, load_data);
    else passed++;
  endtask

  task automatic test_half();
    do_op("sh_030", 1'b1, 3'b001, 32'h030, 32'h00008001);
    total++;
    if (!r_done || r_cyc != 5 || r_op !== 4'b0011 || r_we !== 1'b1)
      $display("FAIL sh_030: done=%b cycles=%0d op=%b we=%b required done=1 cycles=5 op=0011 we=1",
               r_done, r_cyc, r_op, r_we);
    else passed++;
    do_op("lh_030", 1'b0, 3'b001, 32'h030, 32'h0);
    total++;
    if (!r_done || load_data !== 32'hFFFF8001)
      $display("FAIL lh_030: done=%b load_data=%h required done=1 ffff8001", r_done, load_data);
    else passed++;
    do_op("lhu_030", 1'b0, 3'b101, 32'h030, 32'h0);
    total++;
    if (!r_done || load_data !== 32'h00008001)
      $display("FAIL lhu_030: done=%b load_data=%h required done=1 00008001", r_done, load_data);
    else passed++;
    do_op("lw_030", 1'b0, 3'b010, 32'h030, 32'h0);
    total++;
    if (!r_done || load_data !== 32'h33328001)
      $display("FAIL lw_030_neighbours: done=%b load_data=%h required done=1 33328001", r_done, load_data);
    else passed++;
  endtask

  task automatic test_errors();
    int            acc0;
    logic [AW-1:0] a0;
    acc0 = accesses; a0 = mem_addr;
    do_op("lw_013", 1'b0, 3'b010, 32'h013, 32'h0);
    total++;
    if (!r_mis || r_done || r_err || r_cyc != 2)
      $display("FAIL lw_013_misaligned: mis=%b done=%b err=%b cycles=%0d required mis=1 done=0 err=0 cycles=2",
               r_mis, r_done, r_err, r_cyc);
    else passed++;
    total++;
    if (mem_addr !== a0 || accesses != acc0 || load_data !== 32'h33328001)
      $display("FAIL lw_013_no_access: addr=%h accesses=%0d load_data=%h required addr=%h accesses=%0d load_data=33328001",
               mem_addr, accesses, load_data, a0, acc0);
    else passed++;
    do_op("lh_031", 1'b0, 3'b001, 32'h031, 32'h0);
    total++;
    if (!r_mis || r_done || r_err)
      $display("FAIL lh_031_misaligned: mis=%b done=%b err=%b required mis=1 done=0 err=0", r_mis, r_done, r_err);
    else passed++;
    do_op("ld_f3_011", 1'b0, 3'b011, 32'h040, 32'h0);
    total++;
    if (!r_err || r_mis || r_done || r_cyc != 2 || accesses != acc0)
      $display("FAIL load_f3_011: err=%b mis=%b done=%b cycles=%0d accesses=%0d required err=1 cycles=2 accesses=%0d",
               r_err, r_mis, r_done, r_cyc, accesses, acc0);
    else passed++;
    do_op("st_f3_100", 1'b1, 3'b100, 32'h040, 32'h0);
    total++;
    if (!r_err || r_mis || r_done)
      $display("FAIL store_f3_100: err=%b mis=%b done=%b required err=1 mis=0 done=0", r_err, r_mis, r_done);
    else passed++;
  endtask

  task automatic test_timeout();
    stuck = 1'b1;
    do_op("lw_040_stuck", 1'b0, 3'b010, 32'h040, 32'h0);
    total++;
    if (!r_err || r_done || r_cyc != 18)
      $display("FAIL timeout_err: err=%b done=%b cycles=%0d required err=1 done=0 cycles=18", r_err, r_done, r_cyc);
    else passed++;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || bus_err !== 1'b0 || load_data !== 32'h33328001)
      $display("FAIL timeout_idle: busy=%b bus_err=%b load_data=%h required busy=0 bus_err=0 load_data=33328001",
               busy, bus_err, load_data);
    else passed++;
    stuck = 1'b0;
  endtask

  task automatic test_reset_mid();
    mem_lat = 5;
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h010;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 40 && !(mem_addr == 12'h010 && !mem_data_valid); k++) @(negedge clk);
    total++;
    if (!(mem_addr == 12'h010 && mem_data_valid == 1'b0))
      $display("FAIL reset_mid_reach: addr=%h valid=%b required addr=010 valid=0", mem_addr, mem_data_valid);
    else passed++;
    @(negedge clk);
    rst = 1'b1; mem_lat = 0;
    #1;
    total++;
    if ({busy, done, misaligned, bus_err, mem_we, mem_op} !== 9'b0 || mem_addr !== 12'h000 || load_data !== 32'h0)
      $display("FAIL reset_mid_outputs: busy=%b done=%b we=%b op=%b addr=%h ld=%h, all required 0",
               busy, done, mem_we, mem_op, mem_addr, load_data);
    else passed++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    do_op("lw_010_after_rst", 1'b0, 3'b010, 32'h010, 32'h0);
    total++;
    if (!r_done || r_cyc != 8 || load_data !== 32'hDEADBEEF)
      $display("FAIL lw_after_reset: done=%b cycles=%0d load_data=%h required done=1 cycles=8 deadbeef",
               r_done, r_cyc, load_data);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
